// File: rtl/fenotipo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fenotipo_pkg
// Description : Shared constants, loader state encoding and slice helpers
//               for the serially loaded chromosome holder.
// Revision    : 1.0 - initial release
// ============================================================================
package fenotipo_pkg;

    localparam int c_N_LES    = 27;
    localparam int c_LE_BITS  = 15;
    localparam int c_N_OUTS   = 4;
    localparam int c_OUT_BITS = 6;
    localparam int c_CHROM_W  = 453;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } state_e;

    function automatic int le_offset(input int k, input int le_bits);
        return k * le_bits;
    endfunction

    // Output selectors sit directly above the packed LE fields.
    function automatic int out_offset(input int j, input int n_les,
                                      input int le_bits, input int out_bits);
        return n_les * le_bits + j * out_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fenotipo_serial_shift.sv
`default_nettype none
// ============================================================================
// Module      : cromossomo_shift
// Description : Shadow shift register and beat counter for chromosome loads.
// Revision    : 1.0 - initial release
// ============================================================================
module cromossomo_shift
    import fenotipo_pkg::*;
#(
    parameter int CHROM_W = c_CHROM_W,
    parameter int SER_W   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic [SER_W-1:0]   data,
    output logic               full,
    output logic [CHROM_W-1:0] shadow
);

    localparam int c_BEATS = CHROM_W / SER_W;
    localparam int c_CNT_W = $clog2(c_BEATS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_BEATS - 1);

    generate
        if (CHROM_W % SER_W != 0) begin : g_bad_ser_w
            $error("CHROM_W must be a multiple of SER_W");
        end
    endgenerate

    logic [c_CNT_W-1:0]       r_count_q;
    logic [c_CNT_W-1:0]       w_count_d;
    logic [CHROM_W-1:0]       r_shadow_q;
    logic [CHROM_W-1:0]       w_shadow_d;
    logic [CHROM_W+SER_W-1:0] w_cat;

    assign w_cat = {data, r_shadow_q};

    always_comb begin
        w_count_d  = r_count_q;
        w_shadow_d = r_shadow_q;
        if (clear) begin
            w_count_d = '0;
        end else if (shift_en) begin
            w_shadow_d = w_cat[CHROM_W+SER_W-1:SER_W];
            w_count_d  = r_count_q + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q  <= '0;
            r_shadow_q <= '0;
        end else begin
            r_count_q  <= w_count_d;
            r_shadow_q <= w_shadow_d;
        end
    end

    // High in the cycle whose accepted beat completes the chromosome.
    assign full   = shift_en && !clear && (r_count_q == c_LAST);
    assign shadow = r_shadow_q;

endmodule
`default_nettype wire

// File: rtl/fenotipo_serial.sv
`default_nettype none
// ============================================================================
// Module      : fenotipo_serial
// Description : Double-buffered chromosome loader with deferred atomic swap.
// Revision    : 1.0 - initial release
// ============================================================================
module fenotipo_serial
    import fenotipo_pkg::*;
#(
    parameter int N_LES    = c_N_LES,
    parameter int LE_BITS  = c_LE_BITS,
    parameter int N_OUTS   = c_N_OUTS,
    parameter int OUT_BITS = c_OUT_BITS,
    parameter int CHROM_W  = c_CHROM_W,
    parameter int SER_W    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_start,
    input  logic                         load_abort,
    input  logic                         load_valid,
    input  logic [SER_W-1:0]             load_data,
    output logic                         load_ready,
    input  logic                         eval_busy,
    output logic                         busy,
    output logic                         commit,
    output logic                         cfg_valid,
    output logic [15:0]                  gen_count,
    output logic [N_LES*LE_BITS-1:0]     conf_les,
    output logic [N_OUTS*OUT_BITS-1:0]   conf_outs
);

    localparam int c_USED = N_LES * LE_BITS + N_OUTS * OUT_BITS;

    generate
        if (CHROM_W < c_USED) begin : g_bad_chrom_w
            $error("CHROM_W too small for the LE and output fields");
        end
    endgenerate

    state_e               r_state_q, w_state_d;
    logic                 r_ready_q, w_ready_d;
    logic                 r_busy_q, w_busy_d;
    logic                 r_commit_q, w_commit_d;
    logic                 r_cfg_valid_q, w_cfg_valid_d;
    logic [15:0]          r_gen_count_q, w_gen_count_d;
    logic [CHROM_W-1:0]   r_active_q, w_active_d;
    logic                 w_clear;
    logic                 w_shift_en;
    logic                 w_full;
    logic [CHROM_W-1:0]   w_shadow;

    // Abort outranks restart and beats in LOAD; IDLE only reacts to start.
    assign w_clear    = load_start &&
                        ((r_state_q == IDLE) || ((r_state_q == LOAD) && !load_abort));
    assign w_shift_en = (r_state_q == LOAD) && load_valid && !load_start && !load_abort;

    cromossomo_shift #(
        .CHROM_W (CHROM_W),
        .SER_W   (SER_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_clear),
        .shift_en (w_shift_en),
        .data     (load_data),
        .full     (w_full),
        .shadow   (w_shadow)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_commit_d = 1'b0;
        case (r_state_q)
            IDLE: if (load_start) w_state_d = LOAD;
            LOAD: begin
                if (load_abort)  w_state_d = IDLE;
                else if (w_full) w_state_d = PEND;
            end
            PEND: begin
                if (load_abort) begin
                    w_state_d = IDLE;
                end else if (!eval_busy) begin
                    w_commit_d = 1'b1;
                    w_state_d  = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
        w_active_d    = w_commit_d ? w_shadow : r_active_q;
        w_gen_count_d = r_gen_count_q + {15'd0, w_commit_d};
        w_cfg_valid_d = r_cfg_valid_q | w_commit_d;
        w_ready_d     = (w_state_d == LOAD);
        w_busy_d      = (w_state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_ready_q     <= 1'b0;
            r_busy_q      <= 1'b0;
            r_commit_q    <= 1'b0;
            r_cfg_valid_q <= 1'b0;
            r_gen_count_q <= '0;
            r_active_q    <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_ready_q     <= w_ready_d;
            r_busy_q      <= w_busy_d;
            r_commit_q    <= w_commit_d;
            r_cfg_valid_q <= w_cfg_valid_d;
            r_gen_count_q <= w_gen_count_d;
            r_active_q    <= w_active_d;
        end
    end

    assign load_ready = r_ready_q;
    assign busy       = r_busy_q;
    assign commit     = r_commit_q;
    assign cfg_valid  = r_cfg_valid_q;
    assign gen_count  = r_gen_count_q;

    generate
        for (genvar k = 0; k < N_LES; k++) begin : g_les
            assign conf_les[le_offset(k, LE_BITS) +: LE_BITS] =
                r_active_q[le_offset(k, LE_BITS) +: LE_BITS];
        end
        for (genvar j = 0; j < N_OUTS; j++) begin : g_outs
            assign conf_outs[j*OUT_BITS +: OUT_BITS] =
                r_active_q[out_offset(j, N_LES, LE_BITS, OUT_BITS) +: OUT_BITS];
        end
        if (CHROM_W > c_USED) begin : g_spare
            logic w_unused_hi;
            assign w_unused_hi = ^r_active_q[CHROM_W-1:c_USED];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fenotipo_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_fenotipo_serial
// Description : Self-checking bench for the serial chromosome loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fenotipo_serial;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default-parameter instance, SER_W = 1
    logic a_start, a_abort, a_valid, a_data, a_eval;
    logic a_ready, a_busy, a_commit, a_cfgv;
    logic [15:0]  a_gen;
    logic [404:0] a_les;
    logic [23:0]  a_outs;

    fenotipo_serial dut_a (
        .clk(clk), .rst(rst), .load_start(a_start), .load_abort(a_abort),
        .load_valid(a_valid), .load_data(a_data), .load_ready(a_ready),
        .eval_busy(a_eval), .busy(a_busy), .commit(a_commit), .cfg_valid(a_cfgv),
        .gen_count(a_gen), .conf_les(a_les), .conf_outs(a_outs)
    );

    // Default geometry with 3-bit beats
    logic b_start, b_abort, b_valid, b_eval;
    logic [2:0] b_data;
    logic b_ready, b_busy, b_commit, b_cfgv;
    logic [15:0]  b_gen;
    logic [404:0] b_les;
    logic [23:0]  b_outs;

    fenotipo_serial #(.SER_W(3)) dut_b (
        .clk(clk), .rst(rst), .load_start(b_start), .load_abort(b_abort),
        .load_valid(b_valid), .load_data(b_data), .load_ready(b_ready),
        .eval_busy(b_eval), .busy(b_busy), .commit(b_commit), .cfg_valid(b_cfgv),
        .gen_count(b_gen), .conf_les(b_les), .conf_outs(b_outs)
    );

    // Tiny instance: 4-bit chromosome, two 2-bit beats, for cycle tables
    logic t_start, t_abort, t_valid, t_eval;
    logic [1:0] t_data;
    logic t_ready, t_busy, t_commit, t_cfgv;
    logic [15:0] t_gen;
    logic [1:0]  t_les, t_outs;

    fenotipo_serial #(.N_LES(1), .LE_BITS(2), .N_OUTS(1), .OUT_BITS(2),
                      .CHROM_W(4), .SER_W(2)) dut_t (
        .clk(clk), .rst(rst), .load_start(t_start), .load_abort(t_abort),
        .load_valid(t_valid), .load_data(t_data), .load_ready(t_ready),
        .eval_busy(t_eval), .busy(t_busy), .commit(t_commit), .cfg_valid(t_cfgv),
        .gen_count(t_gen), .conf_les(t_les), .conf_outs(t_outs)
    );

    typedef struct {
        logic st, ab, vl;
        logic [1:0] d;
        logic eb;
        logic rdy, bsy, cm, cv;
        logic [15:0] gen;
        logic [1:0] les, outs;
    } vec_t;

    vec_t tv[23];

    function automatic vec_t mk(input logic st, input logic ab, input logic vl,
                                input logic [1:0] d, input logic eb,
                                input logic rdy, input logic bsy, input logic cm,
                                input logic cv, input logic [15:0] gen,
                                input logic [1:0] les, input logic [1:0] outs);
        vec_t v;
        v.st = st; v.ab = ab; v.vl = vl; v.d = d; v.eb = eb;
        v.rdy = rdy; v.bsy = bsy; v.cm = cm; v.cv = cv;
        v.gen = gen; v.les = les; v.outs = outs;
        return v;
    endfunction

    task automatic check(input string name, input logic [511:0] act,
                         input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // LE k field = k + le_add, output j field = j + out_add, spare bits zero
    function automatic logic [452:0] pat(input int le_add, input int out_add);
        logic [452:0] c;
        c = '0;
        for (int k = 0; k < 27; k++) c[k*15 +: 15] = 15'(k + le_add);
        for (int j = 0; j < 4; j++)  c[405 + j*6 +: 6] = 6'(j + out_add);
        return c;
    endfunction

    task automatic a_load(input logic [452:0] c, input int from, input int n);
        for (int i = 0; i < n; i++) begin
            a_valid = 1'b1;
            a_data  = c[from + i];
            tick();
        end
        a_valid = 1'b0;
    endtask

    task automatic a_pulse_start();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    logic [452:0] p1, p2, pr;

    initial begin
        rst = 1'b1;
        {a_start, a_abort, a_valid, a_data, a_eval} = '0;
        {b_start, b_abort, b_valid, b_eval} = '0;
        b_data = '0;
        {t_start, t_abort, t_valid, t_eval} = '0;
        t_data = '0;
        p1 = pat(0, 40);
        p2 = pat(100, 7);

        // Reset held 3 cycles with a beat offered; IDLE must ignore it
        a_valid = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        a_valid = 1'b0;
        check("reset ctrl", {a_ready, a_busy, a_commit, a_cfgv}, 4'b0000);
        check("reset gen", a_gen, 16'd0);
        check("reset les", a_les, 405'd0);
        check("reset outs", a_outs, 24'd0);

        // Cycle table on the tiny instance
        tv[0]  = mk(0,0,1,2'd3,0, 0,0,0,0,16'd0,2'd0,2'd0);
        tv[1]  = mk(1,0,0,2'd0,0, 1,1,0,0,16'd0,2'd0,2'd0);
        tv[2]  = mk(0,0,1,2'd1,0, 1,1,0,0,16'd0,2'd0,2'd0);
        tv[3]  = mk(0,0,1,2'd2,0, 0,1,0,0,16'd0,2'd0,2'd0);
        tv[4]  = mk(0,0,0,2'd0,1, 0,1,0,0,16'd0,2'd0,2'd0);
        tv[5]  = mk(0,0,0,2'd0,0, 0,0,1,1,16'd1,2'd1,2'd2);
        tv[6]  = mk(0,0,0,2'd0,0, 0,0,0,1,16'd1,2'd1,2'd2);
        tv[7]  = mk(1,0,0,2'd0,0, 1,1,0,1,16'd1,2'd1,2'd2);
        tv[8]  = mk(0,0,1,2'd3,0, 1,1,0,1,16'd1,2'd1,2'd2);
        tv[9]  = mk(1,0,1,2'd0,0, 1,1,0,1,16'd1,2'd1,2'd2);
        tv[10] = mk(0,0,1,2'd2,0, 1,1,0,1,16'd1,2'd1,2'd2);
        tv[11] = mk(0,1,1,2'd1,0, 0,0,0,1,16'd1,2'd1,2'd2);
        tv[12] = mk(1,0,0,2'd0,0, 1,1,0,1,16'd1,2'd1,2'd2);
        tv[13] = mk(0,0,1,2'd0,0, 1,1,0,1,16'd1,2'd1,2'd2);
        tv[14] = mk(0,0,1,2'd3,1, 0,1,0,1,16'd1,2'd1,2'd2);
        tv[15] = mk(1,0,0,2'd0,1, 0,1,0,1,16'd1,2'd1,2'd2);
        tv[16] = mk(0,1,0,2'd0,0, 0,0,0,1,16'd1,2'd1,2'd2);
        tv[17] = mk(1,1,0,2'd0,0, 1,1,0,1,16'd1,2'd1,2'd2);
        tv[18] = mk(0,0,1,2'd2,0, 1,1,0,1,16'd1,2'd1,2'd2);
        tv[19] = mk(0,0,0,2'd0,0, 1,1,0,1,16'd1,2'd1,2'd2);
        tv[20] = mk(0,0,1,2'd1,0, 0,1,0,1,16'd1,2'd1,2'd2);
        tv[21] = mk(0,0,0,2'd0,0, 0,0,1,1,16'd2,2'd2,2'd1);
        tv[22] = mk(0,0,0,2'd0,0, 0,0,0,1,16'd2,2'd2,2'd1);

        for (int i = 0; i < 23; i++) begin
            t_start = tv[i].st; t_abort = tv[i].ab; t_valid = tv[i].vl;
            t_data  = tv[i].d;  t_eval  = tv[i].eb;
            tick();
            check($sformatf("tiny vec %0d", i),
                  {t_ready, t_busy, t_commit, t_cfgv, t_gen, t_les, t_outs},
                  {tv[i].rdy, tv[i].bsy, tv[i].cm, tv[i].cv, tv[i].gen, tv[i].les, tv[i].outs});
        end
        {t_start, t_abort, t_valid, t_eval} = '0;

        // Full load, evaluator idle: commit two cycles after the last beat
        a_pulse_start();
        a_load(p1, 0, 453);
        check("pend ctrl", {a_ready, a_busy, a_commit}, 3'b010);
        tick();
        check("commit pulse", a_commit, 1'b1);
        check("le5 slice", a_les[5*15 +: 15], 15'd5);
        check("out3 slice", a_outs[3*6 +: 6], 6'd43);
        check("full les", a_les, p1[404:0]);
        check("full outs", a_outs, p1[428:405]);
        check("gen one", a_gen, 16'd1);
        check("cfg valid", a_cfgv, 1'b1);
        tick();
        check("commit single", {a_commit, a_busy}, 2'b00);

        // Swap deferred by evaluator for 10 cycles
        a_eval = 1'b1;
        a_pulse_start();
        a_load(p2, 0, 453);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("held %0d", i), {a_commit, a_busy, a_les}, {2'b01, p1[404:0]});
            tick();
        end
        a_eval = 1'b0;
        tick();
        check("deferred commit", a_commit, 1'b1);
        check("deferred les", a_les, p2[404:0]);
        check("deferred outs", a_outs, p2[428:405]);
        check("gen two", a_gen, 16'd2);

        // Abort after 200 beats, then a clean reload
        do_reset();
        check("post reset les", a_les, 405'd0);
        check("post reset gen", {a_cfgv, a_gen}, 17'd0);
        a_pulse_start();
        a_load(p1, 0, 200);
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        repeat (4) tick();
        check("abort ctrl", {a_ready, a_busy, a_cfgv}, 3'b000);
        check("abort gen", a_gen, 16'd0);
        check("abort les", a_les, 405'd0);
        a_pulse_start();
        a_load(p1, 0, 453);
        begin
            int n;
            n = 0;
            while (!a_commit && n < 20) begin
                tick();
                n++;
            end
            check("reload latency", n, 1);
        end
        check("reload les", a_les, p1[404:0]);
        check("reload gen", a_gen, 16'd1);
        tick();

        // Restart after 100 junk beats; 453 fresh beats still required
        a_pulse_start();
        a_load({453{1'b1}}, 0, 100);
        a_start = 1'b1; a_valid = 1'b1; a_data = 1'b1;
        tick();
        a_start = 1'b0; a_valid = 1'b0;
        a_load(p2, 0, 452);
        check("restart still loading", {a_ready, a_busy, a_commit}, 3'b110);
        a_load(p2, 452, 1);
        check("restart pend", {a_ready, a_busy}, 2'b01);
        tick();
        check("restart commit", a_commit, 1'b1);
        check("restart les", a_les, p2[404:0]);
        check("restart outs", a_outs, p2[428:405]);
        check("restart gen", a_gen, 16'd2);
        tick();

        // Reset mid-load wipes the active config
        a_pulse_start();
        a_load(p1, 0, 50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("midload rst", {a_ready, a_busy, a_cfgv, a_gen}, 19'd0);
        check("midload rst les", {a_les, a_outs}, 429'd0);

        // 3-bit beats with random valid gaps against a random chromosome
        for (int i = 0; i < 453; i++) pr[i] = 1'($urandom_range(0, 1));
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        begin
            int beat, cyc;
            logic acc;
            beat = 0;
            cyc = 0;
            while (beat < 151 && cyc < 2000) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_data  = pr[3*beat +: 3];
                acc     = b_valid && b_ready;
                tick();
                if (acc) beat++;
                cyc++;
            end
            b_valid = 1'b0;
            check("ser3 beats accepted", beat, 151);
            cyc = 0;
            while (!b_commit && cyc < 10) begin
                tick();
                cyc++;
            end
            check("ser3 commit", b_commit, 1'b1);
        end
        check("ser3 les", b_les, pr[404:0]);
        check("ser3 outs", b_outs, pr[428:405]);
        check("ser3 gen", {b_cfgv, b_gen}, 17'h10001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
